// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - program-counter register with priority next-PC select, stall hold, debug FSM and update counter
module pc_next_unit #(
   parameter int               NBITS      = 32,
   parameter logic [NBITS-1:0] RESET_PC   = '0,
   parameter int               PC_INC     = 4,
   parameter logic [NBITS-1:0] EXC_VECTOR = NBITS'(32'h0000_0080),
   parameter int               CNT_BITS   = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_run,
   input  logic                i_step,
   input  logic                i_stall,
   input  logic                i_halt_detect,
   input  logic                i_exception,
   input  logic                i_JALR,
   input  logic                i_Jump,
   input  logic                i_pcSrc,
   input  logic [NBITS-1:0]    i_rs,
   input  logic [NBITS-1:0]    i_SumadorJump,
   input  logic [NBITS-1:0]    i_SumadorBranch,
   output logic [NBITS-1:0]    o_pc,
   output logic [NBITS-1:0]    o_pc4,
   output logic                o_advance,
   output logic                o_misaligned,
   output logic [1:0]          o_state,
   output logic [CNT_BITS-1:0] o_upd_count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_STEP   = 2'b10,
      ST_HALTED = 2'b11
   } state_t;

   state_t              state;
   logic [NBITS-1:0]    pc;
   logic [NBITS-1:0]    pc_seq;
   logic [NBITS-1:0]    next_pc;
   logic                advance;
   logic                jalr_misaligned;
   logic                misaligned;
   logic [CNT_BITS-1:0] upd_count;

   // Sequential successor; the adder wraps naturally at the register width.
   always_comb begin
      pc_seq = pc + NBITS'(PC_INC);
   end

   // The PC only moves while the debug FSM lets the core execute and nothing holds it.
   always_comb begin
      advance = ((state == ST_RUN) || (state == ST_STEP)) && !i_stall && !i_halt_detect;
   end

   // Fixed-priority target select: exception, JALR, jump, branch, sequential.
   always_comb begin
      next_pc         = pc_seq;
      jalr_misaligned = 1'b0;
      if (i_exception) begin
         next_pc = EXC_VECTOR;
      end else if (i_JALR) begin
         if (i_rs[1:0] != 2'b00) begin
            // A misaligned register target is redirected to the exception vector.
            next_pc         = EXC_VECTOR;
            jalr_misaligned = 1'b1;
         end else begin
            next_pc = i_rs;
         end
      end else if (i_Jump) begin
         next_pc = i_SumadorJump;
      end else if (i_pcSrc) begin
         next_pc = i_SumadorBranch;
      end
   end

   // PC register and the one-cycle misaligned-JALR flag; select inputs matter only on advance.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc         <= RESET_PC;
         misaligned <= 1'b0;
      end else begin
         misaligned <= advance && jalr_misaligned;
         if (advance) begin
            pc <= next_pc;
         end
      end
   end

   // Retired-update counter, saturating at all ones rather than wrapping.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         upd_count <= '0;
      end else if (advance && (upd_count != {CNT_BITS{1'b1}})) begin
         upd_count <= upd_count + 1'b1;
      end
   end

   // Debug run/step/halt state machine; HALTED is left only through reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_run) begin
                  state <= ST_RUN;
               end else if (i_step) begin
                  state <= ST_STEP;
               end
            end
            ST_RUN: begin
               if (i_halt_detect) begin
                  state <= ST_HALTED;
               end
            end
            ST_STEP: begin
               // A stalled step waits here until its single update happens.
               if (i_halt_detect) begin
                  state <= ST_HALTED;
               end else if (advance) begin
                  state <= ST_IDLE;
               end
            end
            ST_HALTED: begin
               state <= ST_HALTED;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output drive.
   always_comb begin
      o_pc         = pc;
      o_pc4        = pc_seq;
      o_advance    = advance;
      o_misaligned = misaligned;
      o_state      = state;
      o_upd_count  = upd_count;
   end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - self-checking bench for pc_next_unit
module tb_pc_next_unit;

   localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALTED = 3;

   logic        i_clk = 1'b0;
   logic        i_reset, i_run, i_step, i_stall, i_halt_detect;
   logic        i_exception, i_JALR, i_Jump, i_pcSrc;
   logic [31:0] i_rs, i_SumadorJump, i_SumadorBranch;

   logic [31:0] o_pc, o_pc4, pc_b, pc4_b;
   logic        o_advance, o_misaligned, adv_b, mis_b;
   logic [1:0]  o_state, state_b;
   logic [15:0] o_upd_count;
   logic [2:0]  cnt_b;

   int tests_run = 0;
   int failed    = 0;

   // reference model
   logic [31:0] m_pc_a, m_pc_b;
   int          m_state;
   int          m_cnt_a, m_cnt_b;
   logic        m_mis;

   always #5 i_clk = ~i_clk;

   pc_next_unit dut_a (
      .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
      .i_stall(i_stall), .i_halt_detect(i_halt_detect), .i_exception(i_exception),
      .i_JALR(i_JALR), .i_Jump(i_Jump), .i_pcSrc(i_pcSrc), .i_rs(i_rs),
      .i_SumadorJump(i_SumadorJump), .i_SumadorBranch(i_SumadorBranch),
      .o_pc(o_pc), .o_pc4(o_pc4), .o_advance(o_advance), .o_misaligned(o_misaligned),
      .o_state(o_state), .o_upd_count(o_upd_count)
   );

   pc_next_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_BITS(3)) dut_b (
      .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
      .i_stall(i_stall), .i_halt_detect(i_halt_detect), .i_exception(i_exception),
      .i_JALR(i_JALR), .i_Jump(i_Jump), .i_pcSrc(i_pcSrc), .i_rs(i_rs),
      .i_SumadorJump(i_SumadorJump), .i_SumadorBranch(i_SumadorBranch),
      .o_pc(pc_b), .o_pc4(pc4_b), .o_advance(adv_b), .o_misaligned(mis_b),
      .o_state(state_b), .o_upd_count(cnt_b)
   );

   function automatic logic [31:0] model_target(input logic [31:0] cur);
      if (i_exception) return 32'h80;
      if (i_JALR) return (i_rs % 4 != 0) ? 32'h80 : i_rs;
      if (i_Jump) return i_SumadorJump;
      if (i_pcSrc) return i_SumadorBranch;
      return cur + 32'd4;
   endfunction

   function automatic logic model_adv();
      return (m_state == M_RUN || m_state == M_STEP) && !i_stall && !i_halt_detect;
   endfunction

   task automatic clr_inputs();
      i_reset = 0; i_run = 0; i_step = 0; i_stall = 0; i_halt_detect = 0;
      i_exception = 0; i_JALR = 0; i_Jump = 0; i_pcSrc = 0;
      i_rs = 0; i_SumadorJump = 0; i_SumadorBranch = 0;
   endtask

   // advance the model with the current inputs, then let the DUT take the same edge
   task automatic tick();
      logic adv;
      adv = model_adv();
      if (i_reset) begin
         m_pc_a = 32'h0; m_pc_b = 32'hFFFF_FFFC; m_state = M_IDLE;
         m_cnt_a = 0; m_cnt_b = 0; m_mis = 0;
      end else begin
         m_mis = adv && !i_exception && i_JALR && (i_rs % 4 != 0);
         if (adv) begin
            m_pc_a = model_target(m_pc_a);
            m_pc_b = model_target(m_pc_b);
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_b < 7) m_cnt_b++;
         end
         case (m_state)
            M_IDLE:  m_state = i_run ? M_RUN : (i_step ? M_STEP : M_IDLE);
            M_RUN:   m_state = i_halt_detect ? M_HALTED : M_RUN;
            M_STEP:  m_state = i_halt_detect ? M_HALTED : (adv ? M_IDLE : M_STEP);
            default: m_state = M_HALTED;
         endcase
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      clr_inputs();
      i_reset = 1;
      tick();
      i_reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      repeat (3) tick();
      tests_run++; if (o_pc !== 32'h0) begin failed++; $display("FAIL reset_pc got %h want %h", o_pc, 32'h0); end
      tests_run++; if (o_state !== 2'b00) begin failed++; $display("FAIL reset_state got %b want 00", o_state); end
      tests_run++; if (o_upd_count !== 16'd0) begin failed++; $display("FAIL reset_count got %0d want 0", o_upd_count); end
      tests_run++; if (o_advance !== 1'b0) begin failed++; $display("FAIL reset_advance got %b want 0", o_advance); end
      tests_run++; if (o_misaligned !== 1'b0) begin failed++; $display("FAIL reset_mis got %b want 0", o_misaligned); end
      tests_run++; if (pc_b !== 32'hFFFF_FFFC) begin failed++; $display("FAIL reset_pc_b got %h want fffffffc", pc_b); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      i_run = 1; tick(); i_run = 0;
      tests_run++; if (o_state !== 2'b01) begin failed++; $display("FAIL run_state got %b want 01", o_state); end
      exp_pc = 32'h0;
      for (int k = 0; k < 4; k++) begin
         tick();
         exp_pc = exp_pc + 32'd4;
         tests_run++; if (o_pc !== exp_pc) begin failed++; $display("FAIL seq_pc[%0d] got %h want %h", k, o_pc, exp_pc); end
      end
      tests_run++; if (o_upd_count !== 16'd4) begin failed++; $display("FAIL seq_count got %0d want 4", o_upd_count); end
      tests_run++; if (o_pc4 !== 32'd20) begin failed++; $display("FAIL seq_pc4 got %h want %h", o_pc4, 32'd20); end
      i_stall = 1; #1;
      tests_run++; if (o_advance !== 1'b0) begin failed++; $display("FAIL stall_advance got %b want 0", o_advance); end
      repeat (2) tick();
      i_stall = 0;
      tests_run++; if (o_pc !== 32'd16) begin failed++; $display("FAIL stall_pc got %h want %h", o_pc, 32'd16); end
      tests_run++; if (o_upd_count !== 16'd4) begin failed++; $display("FAIL stall_count got %0d want 4", o_upd_count); end
   endtask

   task automatic test_priority();
      i_Jump = 1; i_SumadorJump = 32'h100; #1;
      tests_run++; if (o_advance !== 1'b1) begin failed++; $display("FAIL prio_advance got %b want 1", o_advance); end
      tick();
      tests_run++; if (o_pc !== 32'h100) begin failed++; $display("FAIL jump_pc got %h want %h", o_pc, 32'h100); end
      i_JALR = 1; i_rs = 32'h200; tick();
      tests_run++; if (o_pc !== 32'h200) begin failed++; $display("FAIL jalr_over_jump got %h want %h", o_pc, 32'h200); end
      i_JALR = 0; i_Jump = 0; i_pcSrc = 1; i_SumadorBranch = 32'h40; i_exception = 1; tick();
      tests_run++; if (o_pc !== 32'h80) begin failed++; $display("FAIL exc_over_branch got %h want %h", o_pc, 32'h80); end
      clr_inputs();
   endtask

   task automatic test_misaligned();
      i_JALR = 1; i_rs = 32'h205; tick(); clr_inputs();
      tests_run++; if (o_pc !== 32'h80) begin failed++; $display("FAIL mis_pc got %h want %h", o_pc, 32'h80); end
      tests_run++; if (o_misaligned !== 1'b1) begin failed++; $display("FAIL mis_flag got %b want 1", o_misaligned); end
      tick();
      tests_run++; if (o_misaligned !== 1'b0) begin failed++; $display("FAIL mis_pulse_len got %b want 0", o_misaligned); end
      tests_run++; if (o_pc !== 32'h84) begin failed++; $display("FAIL mis_after_pc got %h want %h", o_pc, 32'h84); end
   endtask

   task automatic test_step();
      do_reset();
      i_step = 1; i_stall = 1; tick(); i_step = 0;
      tests_run++; if (o_state !== 2'b10) begin failed++; $display("FAIL step_state got %b want 10", o_state); end
      tick();
      tests_run++; if (o_pc !== 32'h0) begin failed++; $display("FAIL step_stalled_pc got %h want 0", o_pc); end
      tests_run++; if (o_state !== 2'b10) begin failed++; $display("FAIL step_hold_state got %b want 10", o_state); end
      i_stall = 0; tick();
      tests_run++; if (o_pc !== 32'h4) begin failed++; $display("FAIL step_pc got %h want 4", o_pc); end
      tests_run++; if (o_state !== 2'b00) begin failed++; $display("FAIL step_done_state got %b want 00", o_state); end
      tick();
      tests_run++; if (o_pc !== 32'h4) begin failed++; $display("FAIL step_once_pc got %h want 4", o_pc); end
      i_run = 1; i_step = 1; tick(); clr_inputs();
      tests_run++; if (o_state !== 2'b01) begin failed++; $display("FAIL run_wins_state got %b want 01", o_state); end
   endtask

   task automatic test_halt();
      logic [31:0] held;
      tick();
      held = o_pc;
      i_halt_detect = 1; #1;
      tests_run++; if (o_advance !== 1'b0) begin failed++; $display("FAIL halt_advance got %b want 0", o_advance); end
      tick(); i_halt_detect = 0;
      tests_run++; if (o_pc !== held) begin failed++; $display("FAIL halt_pc got %h want %h", o_pc, held); end
      tests_run++; if (o_state !== 2'b11) begin failed++; $display("FAIL halt_state got %b want 11", o_state); end
      i_run = 1; i_step = 1; repeat (3) tick(); clr_inputs();
      tests_run++; if (o_state !== 2'b11) begin failed++; $display("FAIL halt_sticky got %b want 11", o_state); end
      tests_run++; if (o_pc !== held) begin failed++; $display("FAIL halt_hold_pc got %h want %h", o_pc, held); end
      i_run = 1; tick(); i_run = 0; repeat (2) tick();
      i_reset = 1; tick(); i_reset = 0;
      tests_run++; if (o_pc !== 32'h0) begin failed++; $display("FAIL midrun_reset_pc got %h want 0", o_pc); end
      tests_run++; if (o_state !== 2'b00) begin failed++; $display("FAIL midrun_reset_state got %b want 00", o_state); end
   endtask

   task automatic test_wrap_saturate();
      do_reset();
      i_run = 1; tick(); i_run = 0;
      tick();
      tests_run++; if (pc_b !== 32'h0) begin failed++; $display("FAIL wrap_pc got %h want 0", pc_b); end
      repeat (8) tick();
      tests_run++; if (cnt_b !== 3'd7) begin failed++; $display("FAIL sat_count got %0d want 7", cnt_b); end
      tests_run++; if (o_upd_count !== 16'd9) begin failed++; $display("FAIL count9 got %0d want 9", o_upd_count); end
      tests_run++; if (pc_b !== 32'h20) begin failed++; $display("FAIL wrap_seq_pc got %h want %h", pc_b, 32'h20); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         i_reset       = ($urandom % 64) == 0;
         i_run         = ($urandom % 6) == 0;
         i_step        = ($urandom % 6) == 0;
         i_stall       = ($urandom % 4) == 0;
         i_halt_detect = ($urandom % 30) == 0;
         i_exception   = ($urandom % 8) == 0;
         i_JALR        = ($urandom % 4) == 0;
         i_Jump        = ($urandom % 4) == 0;
         i_pcSrc       = ($urandom % 3) == 0;
         i_rs          = $urandom;
         if ($urandom % 2) i_rs = i_rs & ~32'h3;
         i_SumadorJump   = $urandom;
         i_SumadorBranch = $urandom;
         #1;
         tests_run++; if (o_advance !== model_adv()) begin failed++; $display("FAIL rnd_advance[%0d] got %b want %b", n, o_advance, model_adv()); end
         tests_run++; if (o_pc4 !== m_pc_a + 32'd4) begin failed++; $display("FAIL rnd_pc4[%0d] got %h want %h", n, o_pc4, m_pc_a + 32'd4); end
         tick();
         tests_run++; if (o_pc !== m_pc_a) begin failed++; $display("FAIL rnd_pc[%0d] got %h want %h", n, o_pc, m_pc_a); end
         tests_run++; if (pc_b !== m_pc_b) begin failed++; $display("FAIL rnd_pc_b[%0d] got %h want %h", n, pc_b, m_pc_b); end
         tests_run++; if (o_state !== 2'(m_state)) begin failed++; $display("FAIL rnd_state[%0d] got %0d want %0d", n, o_state, m_state); end
         tests_run++; if (o_upd_count !== 16'(m_cnt_a)) begin failed++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, o_upd_count, m_cnt_a); end
         tests_run++; if (cnt_b !== 3'(m_cnt_b)) begin failed++; $display("FAIL rnd_count_b[%0d] got %0d want %0d", n, cnt_b, m_cnt_b); end
         tests_run++; if (o_misaligned !== m_mis) begin failed++; $display("FAIL rnd_mis[%0d] got %b want %b", n, o_misaligned, m_mis); end
      end
      clr_inputs();
   endtask

   initial begin
      clr_inputs();
      #2;
      test_reset();
      test_sequential();
      test_priority();
      test_misaligned();
      test_step();
      test_halt();
      test_wrap_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
